// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single MEMOIRE port between the CPU datapath and a program-loader/debug master.
// The loader may burst freely, but it yields after LDR_MAX_BURST cycles while a CPU access waits.
module mem_bus_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int LDR_MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_owner
);

  localparam int CNT_W = $clog2(LDR_MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LDR_MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    CPU_OWN = 1'b0,
    LDR_OWN = 1'b1
  } owner_t;

  owner_t           state_r;
  owner_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             rd_pending_r;
  owner_t           rd_owner_r;
  logic             cpu_pend_s;

  assign cpu_pend_s = cpu_read | cpu_write;

  // Ownership and burst-length next-state decision
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CPU_OWN: begin
        if (ldr_req) begin
          state_s = LDR_OWN;
        end else begin
          state_s = CPU_OWN;
        end
        cnt_s = {CNT_W{1'b0}};
      end
      LDR_OWN: begin
        if (!ldr_req) begin
          state_s = CPU_OWN;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cpu_pend_s && (cnt_r == CNT_LAST)) begin
          // forced yield: CPU gets at least one full cycle
          state_s = CPU_OWN;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = LDR_OWN;
          cnt_s   = (cnt_r == CNT_LAST) ? cnt_r : (cnt_r + CNT_ONE);
        end
      end
      default: begin
        state_s = CPU_OWN;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Ownership state and burst counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= CPU_OWN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Remember who issued the read so the returning data is steered correctly
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_pending_r <= 1'b0;
      rd_owner_r   <= CPU_OWN;
    end else begin
      rd_pending_r <= mem_re;
      rd_owner_r   <= state_r;
    end
  end

  // Memory port mux; CPU write wins over a simultaneous CPU read
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (!RESET) begin
      mem_re = 1'b0;
      mem_we = 1'b0;
    end else if (state_r == LDR_OWN) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_we    = ldr_req & ldr_we;
      mem_re    = ldr_req & ~ldr_we;
    end else begin
      mem_we = cpu_write;
      mem_re = cpu_read & ~cpu_write;
    end
  end

  assign cpu_rdy    = (state_r == CPU_OWN);
  assign ldr_gnt    = (state_r == LDR_OWN) & ldr_req;
  assign bus_owner  = (state_r == LDR_OWN);
  assign ldr_rvalid = rd_pending_r & (rd_owner_r == LDR_OWN);
  assign ldr_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level ownership/memory model kept in the bench.
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic        CLK;
  logic        RESET;
  logic        cpu_read, cpu_write, cpu_rdy;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_wdata, ldr_rdata;
  logic        mem_re, mem_we, bus_owner;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int n_checks;
  int n_fail;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .LDR_MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .bus_owner(bus_owner)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous memory with one-cycle read latency
  logic [7:0] mem_arr [0:4095];
  always @(posedge CLK) begin
    if (mem_we) mem_arr[mem_addr[11:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_arr[mem_addr[11:0]];
  end

  // Reference model state
  logic [7:0] ref_mem   [0:4095];
  bit         ref_known [0:4095];
  bit         m_owner;
  int         m_used;
  bit         m_prev_rd_ldr, m_prev_rd_cpu, m_prev_known;
  logic [7:0] m_prev_data;

  // Expected values for the current cycle
  bit         e_rdy, e_gnt, e_owner, e_re, e_we, e_rvalid, e_cpu_rd, e_known;
  logic [15:0] e_addr;
  logic [7:0] e_wdata, e_rdata;

  task automatic model_reset();
    m_owner = 1'b0; m_used = 0;
    m_prev_rd_ldr = 1'b0; m_prev_rd_cpu = 1'b0; m_prev_known = 1'b0; m_prev_data = 8'h00;
  endtask

  // Drive one cycle's inputs, compute expectations and advance the model
  task automatic apply(input bit rst, input bit cr, input bit cw, input logic [15:0] ca,
                       input logic [7:0] cd, input bit lr, input bit lw,
                       input logic [15:0] la, input logic [7:0] ld);
    int idx;
    @(negedge CLK);
    RESET = rst; cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
    #1;
    if (!rst) begin
      e_rdy = 1'b1; e_gnt = 1'b0; e_owner = 1'b0; e_re = 1'b0; e_we = 1'b0;
      e_addr = ca; e_wdata = cd; e_rvalid = 1'b0; e_cpu_rd = 1'b0; e_known = 1'b0;
      model_reset();
    end else begin
      e_owner = m_owner; e_rdy = !m_owner; e_gnt = m_owner && lr;
      if (m_owner) begin
        e_addr = la; e_wdata = ld; e_we = lr && lw; e_re = lr && !lw;
      end else begin
        e_addr = ca; e_wdata = cd; e_we = cw; e_re = cr && !cw;
      end
      e_rvalid = m_prev_rd_ldr; e_cpu_rd = m_prev_rd_cpu;
      e_known = m_prev_known; e_rdata = m_prev_data;
      idx = int'(e_addr[11:0]);
      m_prev_rd_ldr = e_re && m_owner;
      m_prev_rd_cpu = e_re && !m_owner;
      m_prev_known  = ref_known[idx];
      m_prev_data   = ref_mem[idx];
      if (e_we) begin
        ref_mem[idx] = e_wdata; ref_known[idx] = 1'b1;
      end
      if (!m_owner) begin
        if (lr) begin m_owner = 1'b1; m_used = 0; end
      end else begin
        m_used++;
        if (!lr) m_owner = 1'b0;
        else if ((cr || cw) && m_used >= MAXB) m_owner = 1'b0;
      end
    end
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 1'b0, 16'h0123, 8'hA5, 1'b1, 1'b0, 16'h0300, 8'h00);
    n_checks++;
    if ({cpu_rdy, ldr_gnt, bus_owner, ldr_rvalid} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 1000", {cpu_rdy, ldr_gnt, bus_owner, ldr_rvalid});
    end
    n_checks++;
    if ({mem_re, mem_we} !== 2'b00 || mem_addr !== 16'h0123) begin
      n_fail++; $display("FAIL reset_mem: got re/we %b addr %h expected 00 0123", {mem_re, mem_we}, mem_addr);
    end
    apply(1'b0, 1'b0, 1'b1, 16'h0124, 8'h3C, 1'b1, 1'b1, 16'h0300, 8'h00);
    n_checks++;
    if ({cpu_rdy, ldr_gnt, mem_we, mem_wdata} !== {3'b100, 8'h3C}) begin
      n_fail++; $display("FAIL reset_hold: got %b/%h expected 100/3c", {cpu_rdy, ldr_gnt, mem_we}, mem_wdata);
    end
  endtask

  task automatic test_cpu_access();
    apply(1'b1, 1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    n_checks++;
    if ({cpu_rdy, mem_re, mem_we, bus_owner, ldr_gnt} !== 5'b11000 || mem_addr !== 16'h0200) begin
      n_fail++; $display("FAIL cpu_read: got %b addr %h expected 11000 addr 0200", {cpu_rdy, mem_re, mem_we, bus_owner, ldr_gnt}, mem_addr);
    end
    apply(1'b1, 1'b0, 1'b1, 16'h0201, 8'h5A, 1'b0, 1'b0, 16'h0000, 8'h00);
    n_checks++;
    if ({cpu_rdy, mem_re, mem_we} !== 3'b101 || mem_addr !== 16'h0201 || mem_wdata !== 8'h5A) begin
      n_fail++; $display("FAIL cpu_write: got %b addr %h data %h expected 101 0201 5a", {cpu_rdy, mem_re, mem_we}, mem_addr, mem_wdata);
    end
    apply(1'b1, 1'b1, 1'b0, 16'h0201, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    idle();
    n_checks++;
    if (cpu_rdata !== 8'h5A || ldr_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL cpu_readback: got %h rvalid %b expected 5a 0", cpu_rdata, ldr_rvalid);
    end
  endtask

  task automatic test_loader_burst_write();
    int i = 0;
    int c = 0;
    logic [7:0] d;
    while (i < 8 && c < 20) begin
      d = 8'(8'h11 * (i + 1));
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'(16'h0300 + i), d);
      n_checks++;
      if (cpu_rdy !== (c == 0) || ldr_gnt !== (c != 0)) begin
        n_fail++; $display("FAIL burst_cycle%0d: got rdy %b gnt %b expected %b %b", c, cpu_rdy, ldr_gnt, c == 0, c != 0);
      end
      if (ldr_gnt) i++;
      c++;
    end
    n_checks++;
    if (i != 8 || c != 9) begin
      n_fail++; $display("FAIL burst_len: got %0d grants in %0d cycles expected 8 in 9", i, c);
    end
    idle();
    idle();
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) apply(1'b1, 1'b1, 1'b0, 16'(16'h0300 + j), 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
      else idle();
      if (j >= 1) begin
        d = 8'(8'h11 * j);
        n_checks++;
        if (cpu_rdata !== d) begin
          n_fail++; $display("FAIL burst_readback%0d: got %h expected %h", j - 1, cpu_rdata, d);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [12:0] pat;
    int rem = 10;
    pat = 13'b0111101111011;
    for (int c = 0; c < 13; c++) begin
      apply(1'b1, 1'b1, 1'b0, 16'h0200, 8'h00, rem > 0, 1'b1, 16'(16'h0500 + (10 - rem)), 8'(rem));
      n_checks++;
      if (ldr_gnt !== pat[12 - c] || cpu_rdy !== !pat[12 - c]) begin
        n_fail++; $display("FAIL fair_cycle%0d: got gnt %b rdy %b expected %b %b", c, ldr_gnt, cpu_rdy, pat[12 - c], !pat[12 - c]);
      end
      if (ldr_gnt) rem--;
    end
    n_checks++;
    if (rem != 0) begin
      n_fail++; $display("FAIL fair_complete: got %0d left expected 0", rem);
    end
    idle();
    idle();
  endtask

  task automatic test_loader_read();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00);
    n_checks++;
    if ({ldr_gnt, cpu_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL lrd_req: got %b expected 01", {ldr_gnt, cpu_rdy});
    end
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00);
    n_checks++;
    if ({ldr_gnt, cpu_rdy, ldr_rvalid, mem_re} !== 4'b1001) begin
      n_fail++; $display("FAIL lrd_gnt: got %b expected 1001", {ldr_gnt, cpu_rdy, ldr_rvalid, mem_re});
    end
    idle();
    n_checks++;
    if ({ldr_gnt, cpu_rdy, ldr_rvalid} !== 3'b001 || ldr_rdata !== 8'h11) begin
      n_fail++; $display("FAIL lrd_data: got %b data %h expected 001 11", {ldr_gnt, cpu_rdy, ldr_rvalid}, ldr_rdata);
    end
    idle();
    n_checks++;
    if ({cpu_rdy, ldr_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL lrd_after: got %b expected 10", {cpu_rdy, ldr_rvalid});
    end
  endtask

  task automatic test_write_precedence();
    apply(1'b1, 1'b1, 1'b1, 16'h0400, 8'h7E, 1'b0, 1'b0, 16'h0000, 8'h00);
    n_checks++;
    if ({mem_we, mem_re} !== 2'b10 || mem_addr !== 16'h0400 || mem_wdata !== 8'h7E) begin
      n_fail++; $display("FAIL wprec: got we/re %b addr %h data %h expected 10 0400 7e", {mem_we, mem_re}, mem_addr, mem_wdata);
    end
    apply(1'b1, 1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    idle();
    n_checks++;
    if (cpu_rdata !== 8'h7E) begin
      n_fail++; $display("FAIL wprec_readback: got %h expected 7e", cpu_rdata);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 4; c++)
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'(16'h0300 + c), 8'h00);
    n_checks++;
    if ({ldr_gnt, ldr_rvalid, bus_owner} !== 3'b111) begin
      n_fail++; $display("FAIL mid_pre: got %b expected 111", {ldr_gnt, ldr_rvalid, bus_owner});
    end
    #1 RESET = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({ldr_gnt, ldr_rvalid, bus_owner, cpu_rdy, mem_re} !== 5'b00010) begin
      n_fail++; $display("FAIL mid_async: got %b expected 00010", {ldr_gnt, ldr_rvalid, bus_owner, cpu_rdy, mem_re});
    end
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00);
    apply(1'b1, 1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    n_checks++;
    if ({cpu_rdy, mem_re, ldr_gnt, ldr_rvalid} !== 4'b1100 || mem_addr !== 16'h0300) begin
      n_fail++; $display("FAIL mid_resume: got %b addr %h expected 1100 0300", {cpu_rdy, mem_re, ldr_gnt, ldr_rvalid}, mem_addr);
    end
    idle();
    n_checks++;
    if (cpu_rdata !== 8'h11 || ldr_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_readback: got %h rvalid %b expected 11 0", cpu_rdata, ldr_rvalid);
    end
  endtask

  task automatic test_random();
    bit cr, cw, lr, lw;
    for (int c = 0; c < 400; c++) begin
      cr = ($urandom_range(0, 99) < 40);
      cw = ($urandom_range(0, 99) < 20);
      lr = ($urandom_range(0, 99) < 70);
      lw = $urandom_range(0, 1) == 1;
      apply(1'b1, cr, cw, 16'(16'h0600 + $urandom_range(0, 31)), 8'($urandom),
            lr, lw, 16'(16'h0600 + $urandom_range(0, 31)), 8'($urandom));
      n_checks++;
      if ({cpu_rdy, ldr_gnt, bus_owner, mem_re, mem_we, ldr_rvalid} !== {e_rdy, e_gnt, e_owner, e_re, e_we, e_rvalid}) begin
        n_fail++; $display("FAIL rnd_ctrl%0d: got %b expected %b", c, {cpu_rdy, ldr_gnt, bus_owner, mem_re, mem_we, ldr_rvalid},
                           {e_rdy, e_gnt, e_owner, e_re, e_we, e_rvalid});
      end
      if (e_re || e_we) begin
        n_checks++;
        if (mem_addr !== e_addr || (e_we && mem_wdata !== e_wdata)) begin
          n_fail++; $display("FAIL rnd_bus%0d: got %h/%h expected %h/%h", c, mem_addr, mem_wdata, e_addr, e_wdata);
        end
      end
      if ((e_rvalid || e_cpu_rd) && e_known) begin
        n_checks++;
        if ((e_rvalid ? ldr_rdata : cpu_rdata) !== e_rdata) begin
          n_fail++; $display("FAIL rnd_rdata%0d: got %h expected %h", c, e_rvalid ? ldr_rdata : cpu_rdata, e_rdata);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int k = 0; k < 4096; k++) ref_known[k] = 1'b0;
    model_reset();
    RESET = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 8'h00;
    test_reset();
    test_cpu_access();
    test_loader_burst_write();
    test_fairness();
    test_loader_read();
    test_write_precedence();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single MEMOIRE port between the CPU datapath/sequencer and an external program-loader/debug master.
- Sits between the CPU address/data buses and MEMOIRE.
- Stalls the CPU sequencer through a ready signal while the loader owns the bus.
- Bounds loader bursts so the CPU is never starved while it has an access pending.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
LDR_MAX_BURST, 4, max consecutive loader accesses while a CPU access is pending (>=1)

Ports:
CLK  input  1  system clock, rising-edge
RESET  input  1  asynchronous, active-low reset
cpu_read  input  1  CPU read request (read_wire)
cpu_write  input  1  CPU write request (write_wire)
cpu_addr  input  ADDR_W  CPU address bus
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  read data to CPU (DATA_IN)
cpu_rdy  output  1  1 = CPU access this cycle is performed; 0 = sequencer must hold state
ldr_req  input  1  loader requests one access this cycle
ldr_we  input  1  loader write (1) / read (0)
ldr_addr  input  ADDR_W  loader address
ldr_wdata  input  DATA_W  loader write data
ldr_gnt  output  1  loader access performed this cycle
ldr_rdata  output  DATA_W  loader read data
ldr_rvalid  output  1  ldr_rdata valid (one cycle after granted read)
mem_re  output  1  memory read enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, synchronous, 1-cycle latency
bus_owner  output  1  0 = CPU, 1 = loader (state register)

Behaviour:
- State register with two states: CPU_OWN (0), LDR_OWN (1). A burst counter of width clog2(LDR_MAX_BURST)+1, plus a registered rd_owner/rd_pending pair for read-return steering.
- Reset (RESET=0, async):
  - state=CPU_OWN, counter=0, ldr_rvalid=0.
  - While in reset: cpu_rdy=1, ldr_gnt=0, bus_owner=0. Memory outputs are driven only from the CPU inputs, and mem_re/mem_we are forced 0.
- Memory mux (combinational on the state):
  - CPU_OWN: mem_* come from cpu_*.
  - LDR_OWN: mem_* come from ldr_* gated by ldr_req.
- Write precedence: if cpu_write and cpu_read are both 1, the write wins (mem_we=1, mem_re=0). For the loader, ldr_we selects write, otherwise read.
- Ready and grant: cpu_rdy = (state==CPU_OWN). ldr_gnt = (state==LDR_OWN) && ldr_req.
- CPU_OWN -> LDR_OWN: at the clock edge where ldr_req=1. Any CPU access presented in that cycle completes normally (cpu_rdy=1 in that cycle). The counter is cleared.
- LDR_OWN, each edge:
  - If ldr_req=0: go to CPU_OWN.
  - Else if (cpu_read|cpu_write) and counter==LDR_MAX_BURST-1: go to CPU_OWN (forced yield).
  - Else: stay in LDR_OWN; counter increments, saturating at LDR_MAX_BURST-1.
  - With no CPU access pending, loader ownership is unlimited.
- Forced yield: the CPU holds the bus for at least one full cycle, because the state is registered. If ldr_req is still 1, the loader regains the bus on the following edge.
- Read return:
  - rd_pending <= mem_re; rd_owner <= state.
  - ldr_rvalid = rd_pending && rd_owner==LDR_OWN; ldr_rdata = mem_rdata.
  - cpu_rdata = mem_rdata, always passed through. The CPU samples it only after its own read.
- A read issued in the last LDR_OWN cycle still returns ldr_rvalid=1 in the first CPU_OWN cycle.
- Reset asserted mid-burst: immediate return to CPU_OWN; ldr_rvalid and any pending read are discarded.
- No combinational path from mem_rdata to any control output.

Test Plan:
- Reset release, loader idle; CPU reads 0x0200 then writes 0x5A to 0x0201 -> cpu_rdy=1 throughout; mem_re then mem_we seen with the matching address/data; bus_owner=0; ldr_gnt=0.
- CPU idle; loader writes 0x11,0x22,...,0x88 to 0x0300..0x0307 with ldr_req held 1 -> 8 consecutive ldr_gnt; memory readback holds those bytes; no forced yield; cpu_rdy=0 from cycle 2 through cycle 9.
- CPU read pending continuously, LDR_MAX_BURST=4, loader requests 10 accesses -> pattern of 4 loader grants, 1 CPU cycle (cpu_rdy=1), 4 grants, 1 CPU, 2 grants; all 10 loader accesses complete.
- Loader reads 0x0300 -> ldr_rvalid=1 exactly one cycle after ldr_gnt with ldr_rdata=0x11; the CPU never sees a stray cpu_rdy=1 during the burst.
- cpu_read and cpu_write asserted together at 0x0400 with data 0x7E -> mem_we=1, mem_re=0; a later read of 0x0400 returns 0x7E.
- Assert RESET=0 during the 3rd cycle of a loader read burst -> state=CPU_OWN, ldr_rvalid=0 and ldr_gnt=0 immediately (asynchronous); after release, cpu_rdy=1 and normal CPU access resumes.
